// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage with IF/ID register, one-entry skid buffer and redirect kill logic.
// Optional FETCH_PERF_EN adds fetch_cnt/flush_cnt performance counters.
module pipeline_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stalld,
    input  logic [1:0]  pcsrcd,
    input  logic [31:0] pcbranchd,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrd,
    output logic [31:0] pcplus4d,
    output logic        validd
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        req_r;
    logic [31:0] pc_r;
    logic [31:0] skid_r;
    logic [31:0] skid_pc4_r;
    logic [31:0] tgt_r;

    logic [31:0] pc_nxt_s;
    logic [31:0] instrd_nxt_s;
    logic [31:0] pcplus4d_nxt_s;
    logic        validd_nxt_s;
    logic [31:0] skid_nxt_s;
    logic [31:0] skid_pc4_nxt_s;
    logic [31:0] tgt_nxt_s;

    logic        ready_s;
    logic        redir_s;
    logic [31:0] target_s;
    logic [31:0] pc4_s;

    // The address is always the PC register: KILL keeps the old PC until the killed response lands.
    assign imem_req  = req_r;
    assign imem_addr = pc_r;

    assign ready_s  = req_r & imem_ready;
    assign redir_s  = validd & ~stalld & (pcsrcd != 2'b00);
    assign target_s = pcsrcd[1] ? {pcplus4d[31:28], instrd[25:0], 2'b00} : pcbranchd;
    assign pc4_s    = pc_r + 32'd4;

    // State register; the request is registered from the next state so it stays low during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= (state_nxt_s != HOLD);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FETCH: begin
                if (ready_s) begin
                    if (!redir_s && stalld) state_nxt_s = HOLD;
                    else                    state_nxt_s = FETCH;
                end else if (redir_s) begin
                    state_nxt_s = KILL;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                if (redir_s || !stalld) state_nxt_s = FETCH;
                else                    state_nxt_s = HOLD;
            end
            KILL: begin
                if (ready_s) state_nxt_s = FETCH;
                else         state_nxt_s = KILL;
            end
            default: state_nxt_s = FETCH;
        endcase
    end

    // Datapath next values: PC, IF/ID register, skid buffer and pending redirect target.
    always_comb begin
        pc_nxt_s       = pc_r;
        instrd_nxt_s   = instrd;
        pcplus4d_nxt_s = pcplus4d;
        validd_nxt_s   = stalld ? validd : 1'b0;
        skid_nxt_s     = skid_r;
        skid_pc4_nxt_s = skid_pc4_r;
        tgt_nxt_s      = tgt_r;
        case (state_r)
            FETCH: begin
                if (ready_s) begin
                    if (redir_s) begin
                        pc_nxt_s     = target_s;
                        validd_nxt_s = 1'b0;
                    end else if (!stalld) begin
                        instrd_nxt_s   = imem_rdata;
                        pcplus4d_nxt_s = pc4_s;
                        validd_nxt_s   = 1'b1;
                        pc_nxt_s       = pc4_s;
                    end else begin
                        skid_nxt_s     = imem_rdata;
                        skid_pc4_nxt_s = pc4_s;
                        pc_nxt_s       = pc4_s;
                    end
                end else if (redir_s) begin
                    tgt_nxt_s    = target_s;
                    validd_nxt_s = 1'b0;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            HOLD: begin
                if (redir_s) begin
                    pc_nxt_s     = target_s;
                    validd_nxt_s = 1'b0;
                end else if (!stalld) begin
                    instrd_nxt_s   = skid_r;
                    pcplus4d_nxt_s = skid_pc4_r;
                    validd_nxt_s   = 1'b1;
                end else begin
                    validd_nxt_s = validd;
                end
            end
            KILL: begin
                if (ready_s) pc_nxt_s = tgt_r;
                else         pc_nxt_s = pc_r;
            end
            default: pc_nxt_s = pc_r;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r       <= RESET_PC;
            instrd     <= 32'h0000_0000;
            pcplus4d   <= 32'h0000_0000;
            validd     <= 1'b0;
            skid_r     <= 32'h0000_0000;
            skid_pc4_r <= 32'h0000_0000;
            tgt_r      <= 32'h0000_0000;
        end else begin
            pc_r       <= pc_nxt_s;
            instrd     <= instrd_nxt_s;
            pcplus4d   <= pcplus4d_nxt_s;
            validd     <= validd_nxt_s;
            skid_r     <= skid_nxt_s;
            skid_pc4_r <= skid_pc4_nxt_s;
            tgt_r      <= tgt_nxt_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_inc_s;

    // Only words that land in instrd or the skid buffer count as fetched.
    assign fetch_inc_s = (state_r == FETCH) & ready_s & ~redir_s;

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            fetch_cnt <= fetch_cnt + {31'd0, fetch_inc_s};
            flush_cnt <= flush_cnt + {31'd0, redir_s};
        end
    end
`endif

endmodule
